// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master sequencer.
//   spi_state_e : controller state encoding
//   spi_mode_t  : SPI mode, bit CPOL_BIT = clock polarity, bit CPHA_BIT = phase
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    XFER,
    CS_WAIT,
    HOLD,
    DESEL
  } spi_state_e;

  localparam int CPOL_BIT = 1;
  localparam int CPHA_BIT = 0;

  typedef logic [1:0] spi_mode_t;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator for the SPI master.
//   clk, rst_n : system clock, async active-low reset
//   en         : count enable; while low the count is held at its reload value
//   tick       : one-cycle pulse every CLK_DIV cycles of en being high
module spi_clk_div
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int            CW        = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LP_RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;

  assign tick = en && (r_cnt == '0);

  // Down-counter: reloading on terminal count or while disabled means every
  // fresh enable yields its first tick exactly CLK_DIV cycles later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= LP_RELOAD;
    end else if (!en || (r_cnt == '0)) begin
      r_cnt <= LP_RELOAD;
    end else begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master sequencer: frames host bytes onto SCL/CS_n/MOSI in any of the
// four SPI modes and assembles MISO into received bytes.
//   clk, rst_n            : system clock, async active-low reset
//   mode                  : SPI mode (CPOL, CPHA), latched on first byte of a frame
//   tx_valid/ready        : host byte handshake; tx_data, tx_last (end frame)
//   rx_data, rx_valid     : received byte and its one-cycle strobe
//   busy                  : controller not idle
//   SCL, CS_n, MOSI, MISO : SPI bus pins
//
// state   | meaning
// IDLE    | CS_n high, SCL follows CPOL input, ready for first byte
// SETUP   | CS_n low, MSB on MOSI, one half-period before first edge
// XFER    | 2*DATA_W SCL edges, one per half-period tick
// CS_WAIT | byte done, frame open; waiting for the next byte
// HOLD    | CS_n still low for one half-period after the last edge
// DESEL   | CS_n high for one half-period before accepting a new frame
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        mode,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_last,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              SCL,
  output logic              CS_n,
  output logic              MOSI,
  input  logic              MISO
);

  localparam int            EW            = $clog2(2*DATA_W + 1);
  localparam logic [EW-1:0] LP_FIRST_EDGE = EW'(1);
  localparam logic [EW-1:0] LP_LAST_EDGE  = EW'(2*DATA_W);

  spi_state_e        r_state;
  spi_mode_t         r_mode;
  logic              r_last;
  logic              r_scl;
  logic              r_cs_n;
  logic              r_tx_ready;
  logic              r_rx_valid;
  logic [DATA_W-1:0] r_shift_tx;
  logic [DATA_W-1:0] r_shift_rx;
  logic [DATA_W-1:0] r_rx_data;
  logic [EW-1:0]     r_edge_cnt;

  logic              w_en;
  logic              w_tick;
  logic              w_accept;
  logic              w_odd;
  logic              w_sample;
  logic              w_shift;
  logic              w_last_edge;
  logic [EW-1:0]     w_edge;
  logic [DATA_W-1:0] w_rx_next;

  // Every exit from these states happens on a tick, so the divider has just
  // reloaded and each state entry starts a fresh half-period.
  assign w_en = (r_state == SETUP) || (r_state == XFER) ||
                (r_state == HOLD)  || (r_state == DESEL);

  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (w_en),
    .tick  (w_tick)
  );

  assign w_accept    = tx_valid && r_tx_ready;
  assign w_edge      = r_edge_cnt + LP_FIRST_EDGE;
  assign w_odd       = w_edge[0];
  assign w_last_edge = (w_edge == LP_LAST_EDGE);
  assign w_sample    = r_mode[CPHA_BIT] ? ~w_odd : w_odd;
  // Edge 1 never shifts (MSB was placed in SETUP); the final edge does not
  // shift either so bit 0 stays on MOSI through the hold time.
  assign w_shift     = (r_mode[CPHA_BIT] ? w_odd : ~w_odd) &&
                       (w_edge != LP_FIRST_EDGE) && !w_last_edge;
  assign w_rx_next   = {r_shift_rx[DATA_W-2:0], MISO};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_mode     <= '0;
      r_last     <= 1'b0;
      r_scl      <= 1'b0;
      r_cs_n     <= 1'b1;
      r_tx_ready <= 1'b0;
      r_rx_valid <= 1'b0;
      r_shift_tx <= '0;
      r_shift_rx <= '0;
      r_rx_data  <= '0;
      r_edge_cnt <= '0;
    end else begin
      r_rx_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cs_n     <= 1'b1;
          r_tx_ready <= 1'b1;
          r_scl      <= mode[CPOL_BIT];
          if (w_accept) begin
            r_mode <= mode;
          end
        end
        SETUP: begin
          if (w_tick) begin
            r_state <= XFER;
          end
        end
        XFER: begin
          if (w_tick) begin
            r_scl      <= ~r_scl;
            r_edge_cnt <= w_edge;
            if (w_sample) begin
              r_shift_rx <= w_rx_next;
            end
            if (w_shift) begin
              r_shift_tx <= r_shift_tx << 1;
            end
            if (w_last_edge) begin
              // CPHA=1 samples on the last edge itself, so fold in MISO now.
              r_rx_data  <= w_sample ? w_rx_next : r_shift_rx;
              r_rx_valid <= 1'b1;
              if (r_last) begin
                r_state <= HOLD;
              end else begin
                r_state    <= CS_WAIT;
                r_tx_ready <= 1'b1;
              end
            end
          end
        end
        CS_WAIT: begin
          r_scl <= r_mode[CPOL_BIT];
        end
        HOLD: begin
          if (w_tick) begin
            r_cs_n  <= 1'b1;
            r_state <= DESEL;
          end
        end
        DESEL: begin
          if (w_tick) begin
            r_state    <= IDLE;
            r_tx_ready <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase

      // Accept is only possible in IDLE or CS_WAIT (the only states that
      // hold tx_ready high); it overrides the per-state updates above.
      if (w_accept) begin
        r_state    <= SETUP;
        r_cs_n     <= 1'b0;
        r_tx_ready <= 1'b0;
        r_shift_tx <= tx_data;
        r_last     <= tx_last;
        r_edge_cnt <= '0;
      end
    end
  end

  assign tx_ready = r_tx_ready;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign busy     = (r_state != IDLE);
  assign SCL      = r_scl;
  assign CS_n     = r_cs_n;
  assign MOSI     = r_shift_tx[DATA_W-1];

endmodule

// File: tb/tb_spi_master_ctrl.sv
module tb_spi_master_ctrl;

  localparam int CLK_DIV = 4;
  localparam int DATA_W  = 8;
  localparam int RX_LAT  = (2*DATA_W + 1) * CLK_DIV;

  typedef struct {
    logic [7:0] rx;
    logic [7:0] tx;
    int         t;
  } sb_t;

  logic       clk;
  logic       rst_n;
  logic [1:0] mode;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       tx_last;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       SCL;
  logic       CS_n;
  logic       MOSI;
  logic       MISO;

  int checks   = 0;
  int failures = 0;
  int ncyc     = 0;

  sb_t sbq[$];

  // slave / bus monitor state
  logic       loopback = 1'b0;
  logic [7:0] miso_pat = 8'h00;
  logic [7:0] s_tx     = 8'h00;
  logic [7:0] mosi_cap = 8'h00;
  logic       mon_cpol = 1'b0;
  logic       mon_cpha = 1'b0;
  logic       cs_prev  = 1'b1;
  logic       scl_prev = 1'b0;
  logic       rdy_prev = 1'b0;
  int         edges        = 0;
  int         rx_count     = 0;
  int         cs_rises     = 0;
  int         wait_toggles = 0;
  int         cs_run       = 0;
  int         min_desel    = 1000;
  logic       had_frame    = 1'b0;

  assign MISO = loopback ? MOSI : s_tx[7];

  spi_master_ctrl #(
    .CLK_DIV (CLK_DIV),
    .DATA_W  (DATA_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mode     (mode),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .tx_last  (tx_last),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .busy     (busy),
    .SCL      (SCL),
    .CS_n     (CS_n),
    .MOSI     (MOSI),
    .MISO     (MISO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) ncyc = ncyc + 1;

  // Slave model and scoreboard consumer, evaluated away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      edges    = 0;
      cs_prev  = 1'b1;
      scl_prev = SCL;
      rdy_prev = 1'b0;
    end else begin
      if (cs_prev && !CS_n) begin
        edges    = 0;
        s_tx     = miso_pat;
        mon_cpol = mode[1];
        mon_cpha = mode[0];
        if (had_frame && cs_run < min_desel) min_desel = cs_run;
        had_frame = 1'b1;
        checks++;
        if (SCL !== mon_cpol) begin
          failures++;
          $display("FAIL scl_idle_at_cs got=%b exp=%b", SCL, mon_cpol);
        end
      end
      if (!cs_prev && CS_n) cs_rises++;
      if (CS_n) cs_run++;
      else cs_run = 0;
      if (!cs_prev && !CS_n && (SCL !== scl_prev)) begin
        edges++;
        if (tx_ready && rdy_prev) wait_toggles++;
        if ((edges % 2 == 1) != mon_cpha) begin
          mosi_cap = {mosi_cap[6:0], MOSI};
          s_tx     = s_tx << 1;
          checks++;
          if (SCL !== ~(mon_cpol ^ mon_cpha)) begin
            failures++;
            $display("FAIL sample_edge_level edge=%0d scl=%b exp=%b", edges, SCL,
                     ~(mon_cpol ^ mon_cpha));
          end
        end
        if (edges == 2*DATA_W) edges = 0;
      end
      if (rx_valid) begin
        sb_t e;
        rx_count++;
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rx_unexpected rx_data=%h at cycle %0d", rx_data, ncyc);
        end else begin
          e = sbq.pop_front();
          checks++;
          if (rx_data !== e.rx) begin
            failures++;
            $display("FAIL rx_data got=%h exp=%h", rx_data, e.rx);
          end
          checks++;
          if (mosi_cap !== e.tx) begin
            failures++;
            $display("FAIL mosi_bits got=%h exp=%h", mosi_cap, e.tx);
          end
          checks++;
          if (ncyc !== e.t) begin
            failures++;
            $display("FAIL rx_valid_time got=%0d exp=%0d", ncyc, e.t);
          end
          checks++;
          if (SCL !== mon_cpol) begin
            failures++;
            $display("FAIL scl_after_byte got=%b exp=%b", SCL, mon_cpol);
          end
        end
      end
      cs_prev  = CS_n;
      scl_prev = SCL;
      rdy_prev = tx_ready;
    end
  end

  task automatic send(input logic [7:0] d, input logic last, output int t_acc);
    int  n;
    sb_t e;
    n = 0;
    @(negedge clk);
    tx_data  = d;
    tx_last  = last;
    tx_valid = 1'b1;
    while (!tx_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      checks++;
      failures++;
      $display("FAIL send_timeout data=%h tx_ready=%b exp=1", d, tx_ready);
      tx_valid = 1'b0;
      t_acc    = -1;
      return;
    end
    t_acc = ncyc + 1;
    e.rx  = loopback ? d : miso_pat;
    e.tx  = d;
    e.t   = t_acc + RX_LAT;
    sbq.push_back(e);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout busy=%b exp=0", busy);
    end
  endtask

  task automatic wait_rx(input int target);
    int n;
    n = 0;
    while (rx_count < target && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      checks++;
      failures++;
      $display("FAIL rx_timeout count=%0d exp=%0d", rx_count, target);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({SCL, CS_n, MOSI, tx_ready, rx_valid, busy, rx_data} !== {6'b010000, 8'h00}) begin
      failures++;
      $display("FAIL reset_values got=%b exp=%b",
               {SCL, CS_n, MOSI, tx_ready, rx_valid, busy, rx_data}, {6'b010000, 8'h00});
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (tx_ready !== 1'b0) begin
      failures++;
      $display("FAIL ready_before_clk got=%b exp=0", tx_ready);
    end
    @(negedge clk);
    checks++;
    if (tx_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_clk got=%b exp=1", tx_ready);
    end
  endtask

  task automatic test_mode0();
    int t;
    int n;
    mode     = 2'd0;
    loopback = 1'b0;
    miso_pat = 8'h3C;
    repeat (2) @(negedge clk);
    send(8'hA5, 1'b1, t);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_in_frame got=%b exp=1", busy);
    end
    n = 0;
    while (!CS_n && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (ncyc !== t + RX_LAT + CLK_DIV) begin
      failures++;
      $display("FAIL cs_rise_time got=%0d exp=%0d", ncyc, t + RX_LAT + CLK_DIV);
    end
    wait_idle();
    checks++;
    if (ncyc !== t + RX_LAT + 2*CLK_DIV || tx_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_desel cyc=%0d rdy=%b exp_cyc=%0d",
               ncyc, tx_ready, t + RX_LAT + 2*CLK_DIV);
    end
  endtask

  task automatic test_mode3_loopback();
    int t;
    mode     = 2'd3;
    loopback = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (SCL !== 1'b1) begin
      failures++;
      $display("FAIL scl_idle_mode3 got=%b exp=1", SCL);
    end
    send(8'h81, 1'b1, t);
    wait_idle();
    checks++;
    if (rx_data !== 8'h81) begin
      failures++;
      $display("FAIL loopback_rx got=%h exp=81", rx_data);
    end
  endtask

  task automatic test_burst();
    int t;
    int r0;
    int c0;
    int w0;
    logic [7:0] bytes [3];
    bytes    = '{8'h11, 8'h22, 8'h33};
    mode     = 2'd0;
    loopback = 1'b1;
    repeat (3) @(negedge clk);
    r0 = rx_count;
    c0 = cs_rises;
    w0 = wait_toggles;
    for (int i = 0; i < 3; i++) begin
      send(bytes[i], (i == 2), t);
      if (i < 2) begin
        wait_rx(r0 + i + 1);
        repeat (12) @(negedge clk);
        checks++;
        if (CS_n !== 1'b0) begin
          failures++;
          $display("FAIL cs_low_in_wait byte=%0d got=%b exp=0", i, CS_n);
        end
      end
    end
    wait_idle();
    checks++;
    if (rx_count - r0 !== 3) begin
      failures++;
      $display("FAIL burst_rx_pulses got=%0d exp=3", rx_count - r0);
    end
    checks++;
    if (cs_rises - c0 !== 1) begin
      failures++;
      $display("FAIL burst_cs_rises got=%0d exp=1", cs_rises - c0);
    end
    checks++;
    if (wait_toggles - w0 !== 0) begin
      failures++;
      $display("FAIL scl_toggle_in_wait got=%0d exp=0", wait_toggles - w0);
    end
  endtask

  task automatic test_reset_mid();
    int t;
    int n;
    int r0;
    mode     = 2'd1;
    loopback = 1'b0;
    miso_pat = 8'hE7;
    repeat (3) @(negedge clk);
    send(8'hB4, 1'b1, t);
    n = 0;
    while (edges < 6 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL edge6_timeout edges=%0d exp=6", edges);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({CS_n, SCL, MOSI, tx_ready, busy} !== 5'b10000) begin
      failures++;
      $display("FAIL async_reset got=%b exp=10000", {CS_n, SCL, MOSI, tx_ready, busy});
    end
    sbq.delete();
    r0 = rx_count;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (80) @(negedge clk);
    checks++;
    if (rx_count !== r0) begin
      failures++;
      $display("FAIL partial_byte_rx got=%0d exp=%0d", rx_count, r0);
    end
    miso_pat = 8'hC3;
    send(8'h5A, 1'b1, t);
    wait_idle();
    checks++;
    if (rx_count !== r0 + 1) begin
      failures++;
      $display("FAIL post_reset_rx got=%0d exp=%0d", rx_count, r0 + 1);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    int r0;
    sb_t e;
    logic [7:0] d [4];
    logic [1:0] m_next [4];
    d        = '{8'h3A, 8'hC5, 8'h0F, 8'hE1};
    m_next   = '{2'd3, 2'd1, 2'd2, 2'd2};
    mode     = 2'd0;
    loopback = 1'b0;
    miso_pat = 8'h96;
    repeat (3) @(negedge clk);
    had_frame = 1'b0;
    min_desel = 1000;
    r0        = rx_count;
    tx_valid  = 1'b1;
    tx_last   = 1'b1;
    tx_data   = d[0];
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (!tx_ready && n < 300) begin
        @(negedge clk);
        n++;
      end
      if (n >= 300) begin
        checks++;
        failures++;
        $display("FAIL b2b_ready_timeout frame=%0d tx_ready=%b exp=1", i, tx_ready);
        break;
      end
      e.rx = miso_pat;
      e.tx = d[i];
      e.t  = ncyc + 1 + RX_LAT;
      sbq.push_back(e);
      @(negedge clk);
      if (i < 3) tx_data = d[i+1];
      else tx_valid = 1'b0;
      repeat (20) @(negedge clk);
      mode = m_next[i];
    end
    tx_valid = 1'b0;
    wait_idle();
    checks++;
    if (rx_count - r0 !== 4) begin
      failures++;
      $display("FAIL b2b_rx_pulses got=%0d exp=4", rx_count - r0);
    end
    checks++;
    if (min_desel < CLK_DIV) begin
      failures++;
      $display("FAIL desel_time got=%0d exp>=%0d", min_desel, CLK_DIV);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    mode     = 2'd0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    tx_last  = 1'b0;
    test_reset();
    test_mode0();
    test_mode3_loopback();
    test_burst();
    test_reset_mid();
    test_back_to_back();
    repeat (4) @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_left got=%0d exp=0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    failures++;
    $display("FAIL watchdog cycle=%0d", ncyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
